// File: rtl/shiftout_pkg.sv
// Shared types and helpers for the daisy-chained shift-register output driver.
package shiftout_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    // Counter width that stays at least one bit for degenerate ranges.
    function automatic int clog2_min1(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/shiftout_chain_if.sv
// Frame handshake between the frame logic (master) and the shift-out driver (slave).
interface shiftout_chain_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CHANNELS   = 2
);
    logic [CHANNELS*DATA_WIDTH-1:0] IN_DATA;
    logic                           IN_VALID;
    logic                           IN_READY;

    modport master (output IN_DATA, output IN_VALID, input  IN_READY);
    modport slave  (input  IN_DATA, input  IN_VALID, output IN_READY);
endinterface

// File: rtl/shiftout_lane.sv
// One serial lane: parallel-load shift register presenting its current output bit.
module shiftout_lane #(
    parameter int DATA_WIDTH = 32,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  load,
    input  logic                  shift,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  bit_out
);

    logic [DATA_WIDTH-1:0] sreg;

    // Zeros are shifted in, so the lane idles at 0 once a frame has been sent.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= load_data;
        end else if (shift) begin
            sreg <= MSB_FIRST ? (sreg << 1) : (sreg >> 1);
        end
    end

    assign bit_out = MSB_FIRST ? sreg[DATA_WIDTH-1] : sreg[0];

endmodule

// File: rtl/shiftout_chain.sv
// Multi-lane 74HC595-style serial driver: shared shift clock and latch, one-deep frame buffer.
module shiftout_chain
    import shiftout_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int CHANNELS     = 2,
    parameter int CLKS_PER_BIT = 12_000,
    parameter bit MSB_FIRST    = 1'b1
) (
    input  logic                CLK,
    input  logic                RST_N,
    shiftout_chain_if.slave     in_if,
    output logic                SHIFT_CLOCK,
    output logic [CHANNELS-1:0] SHIFT_DATA,
    output logic                SHIFT_LATCH,
    output logic                BUSY,
    output logic                FRAME_DONE
);

    localparam int FW = CHANNELS * DATA_WIDTH;
    localparam int PW = clog2_min1(CLKS_PER_BIT);
    localparam int BW = clog2_min1(DATA_WIDTH);
    localparam logic [PW-1:0] PHASE_LAST = PW'(CLKS_PER_BIT - 1);
    localparam logic [PW-1:0] PHASE_HALF = PW'(CLKS_PER_BIT / 2);
    localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_WIDTH - 1);

    if (CLKS_PER_BIT < 2 || (CLKS_PER_BIT % 2) != 0) begin : g_bad_cpb
        $error("shiftout_chain: CLKS_PER_BIT must be even and >= 2");
    end
    if (DATA_WIDTH < 1 || CHANNELS < 1) begin : g_bad_size
        $error("shiftout_chain: DATA_WIDTH and CHANNELS must be >= 1");
    end

    state_t          state, state_nxt;
    logic [PW-1:0]   phase, phase_nxt;
    logic [BW-1:0]   bit_cnt, bit_nxt;
    logic            hold_full;
    logic [FW-1:0]   hold_data;
    logic [FW-1:0]   load_data;
    logic            accept, phase_end;
    logic            lane_load, lane_shift, hold_wr, hold_clr;

    assign in_if.IN_READY = ~hold_full;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        accept     = in_if.IN_VALID && !hold_full;
        phase_end  = (phase == PHASE_LAST);
        state_nxt  = state;
        phase_nxt  = phase_end ? '0 : phase + 1'b1;
        bit_nxt    = bit_cnt;
        lane_load  = 1'b0;
        lane_shift = 1'b0;
        load_data  = in_if.IN_DATA;
        hold_wr    = 1'b0;
        hold_clr   = 1'b0;

        unique case (state)
            IDLE: begin
                phase_nxt = '0;
                bit_nxt   = '0;
                if (accept) begin
                    lane_load = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                hold_wr = accept;
                if (phase_end) begin
                    lane_shift = 1'b1;
                    if (bit_cnt == BIT_LAST) begin
                        state_nxt = LATCH;
                        bit_nxt   = '0;
                    end else begin
                        bit_nxt = bit_cnt + 1'b1;
                    end
                end
            end
            LATCH: begin
                // On the decision edge a fresh frame bypasses the empty hold register.
                hold_wr = accept && !phase_end;
                if (phase_end) begin
                    if (hold_full) begin
                        lane_load = 1'b1;
                        load_data = hold_data;
                        hold_clr  = 1'b1;
                        state_nxt = SHIFT;
                    end else if (accept) begin
                        lane_load = 1'b1;
                        state_nxt = SHIFT;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                phase_nxt = '0;
                bit_nxt   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state       <= IDLE;
            phase       <= '0;
            bit_cnt     <= '0;
            hold_full   <= 1'b0;
            SHIFT_CLOCK <= 1'b0;
            SHIFT_LATCH <= 1'b1;
            BUSY        <= 1'b0;
            FRAME_DONE  <= 1'b0;
        end else begin
            state   <= state_nxt;
            phase   <= phase_nxt;
            bit_cnt <= bit_nxt;
            if (hold_wr) begin
                hold_full <= 1'b1;
            end else if (hold_clr) begin
                hold_full <= 1'b0;
            end
            // Outputs are registered from the next-state decode, so they line up with state.
            SHIFT_CLOCK <= (state_nxt == SHIFT) && (phase_nxt >= PHASE_HALF);
            SHIFT_LATCH <= (state_nxt == IDLE) ||
                           ((state_nxt == LATCH) && (phase_nxt >= PHASE_HALF));
            BUSY        <= (state_nxt != IDLE);
            FRAME_DONE  <= (state_nxt == LATCH) && (phase_nxt == PHASE_LAST);
        end
    end

    // NOTE: hold_data carries no reset; hold_full alone says whether it is meaningful.
    always_ff @(posedge CLK) begin
        if (hold_wr) begin
            hold_data <= in_if.IN_DATA;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        shiftout_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .MSB_FIRST  (MSB_FIRST)
        ) u_lane (
            .CLK       (CLK),
            .RST_N     (RST_N),
            .load      (lane_load),
            .shift     (lane_shift),
            .load_data (load_data[c*DATA_WIDTH +: DATA_WIDTH]),
            .bit_out   (SHIFT_DATA[c])
        );
    end

endmodule

// File: tb/tb_shiftout_chain.sv
// Directed bench for shiftout_chain: MSB-first and LSB-first instances, 8-bit x 2 lanes, 4 clocks/bit.
module tb_shiftout_chain;

    localparam int DW  = 8;
    localparam int CH  = 2;
    localparam int CPB = 4;

    logic CLK = 1'b0;
    logic RST_N;
    always #5 CLK = ~CLK;

    shiftout_chain_if #(.DATA_WIDTH(DW), .CHANNELS(CH)) m_if ();
    shiftout_chain_if #(.DATA_WIDTH(DW), .CHANNELS(CH)) l_if ();

    logic          m_sclk, m_latch, m_busy, m_fd;
    logic [CH-1:0] m_sdata;
    logic          l_sclk, l_latch, l_busy, l_fd;
    logic [CH-1:0] l_sdata;

    shiftout_chain #(.DATA_WIDTH(DW), .CHANNELS(CH), .CLKS_PER_BIT(CPB), .MSB_FIRST(1'b1)) dut_msb (
        .CLK(CLK), .RST_N(RST_N), .in_if(m_if),
        .SHIFT_CLOCK(m_sclk), .SHIFT_DATA(m_sdata), .SHIFT_LATCH(m_latch),
        .BUSY(m_busy), .FRAME_DONE(m_fd)
    );

    shiftout_chain #(.DATA_WIDTH(DW), .CHANNELS(CH), .CLKS_PER_BIT(CPB), .MSB_FIRST(1'b0)) dut_lsb (
        .CLK(CLK), .RST_N(RST_N), .in_if(l_if),
        .SHIFT_CLOCK(l_sclk), .SHIFT_DATA(l_sdata), .SHIFT_LATCH(l_latch),
        .BUSY(l_busy), .FRAME_DONE(l_fd)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int nrise, nlrise, nfd, nbusy, lrise_cyc, l_nrise;
    int fall_q[$];
    logic [31:0] sh0, sh1, l_sh0;
    logic p_sclk = 1'b0, p_latch = 1'b0, lp_sclk = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic clear();
        nrise = 0; nlrise = 0; nfd = 0; nbusy = 0; lrise_cyc = -1; l_nrise = 0;
        sh0 = '0; sh1 = '0; l_sh0 = '0;
        fall_q.delete();
    endtask

    // Advance one clock, sample #1 after the edge and update the event trackers.
    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
        if (m_sclk === 1'b1 && p_sclk === 1'b0) begin
            nrise++;
            sh0 = {sh0[30:0], m_sdata[0]};
            sh1 = {sh1[30:0], m_sdata[1]};
        end
        if (m_latch === 1'b1 && p_latch === 1'b0) begin
            nlrise++;
            lrise_cyc = cyc;
        end
        if (m_latch === 1'b0 && p_latch === 1'b1) fall_q.push_back(cyc);
        if (m_fd === 1'b1) nfd++;
        if (m_busy === 1'b1) nbusy++;
        if (l_sclk === 1'b1 && lp_sclk === 1'b0) begin
            l_nrise++;
            l_sh0 = {l_sh0[30:0], l_sdata[0]};
        end
        p_sclk  = m_sclk;
        p_latch = m_latch;
        lp_sclk = l_sclk;
    endtask

    initial begin
        int entry;
        int nacc;
        bit acc;
        bit found;
        logic [15:0] frames [3];

        RST_N = 1'b0;
        m_if.IN_VALID = 1'b0; m_if.IN_DATA = '0;
        l_if.IN_VALID = 1'b0; l_if.IN_DATA = '0;
        clear();

        // Reset state
        repeat (3) step();
        check("rst_latch", m_latch, 1'b1);
        check("rst_sclk",  m_sclk,  1'b0);
        check("rst_sdata", m_sdata, 2'b00);
        check("rst_busy",  m_busy,  1'b0);
        check("rst_ready", m_if.IN_READY, 1'b1);
        check("rst_fd",    m_fd,    1'b0);
        RST_N = 1'b1;
        repeat (2) step();

        // Single frame, MSB first: lane0=A5, lane1=3C
        clear();
        m_if.IN_DATA = {8'h3C, 8'hA5}; m_if.IN_VALID = 1'b1;
        step();
        entry = cyc;
        m_if.IN_VALID = 1'b0;
        check("s1_entry_latch", m_latch, 1'b0);
        check("s1_entry_bits",  m_sdata, 2'b01);
        repeat (50) step();
        check("s1_nrise",     nrise, 8);
        check("s1_lane0",     sh0[7:0], 8'hA5);
        check("s1_lane1",     sh1[7:0], 8'h3C);
        check("s1_latch_rel", lrise_cyc - entry, 34);
        check("s1_busy_len",  nbusy, 36);
        check("s1_fd_count",  nfd, 1);
        check("s1_idle_latch", m_latch, 1'b1);

        // LSB first: lane0=01 -> 1 then seven 0s
        clear();
        l_if.IN_DATA = {8'h00, 8'h01}; l_if.IN_VALID = 1'b1;
        step();
        l_if.IN_VALID = 1'b0;
        check("s2_entry_bits", l_sdata, 2'b01);
        repeat (45) step();
        check("s2_nrise", l_nrise, 8);
        check("s2_lane0", l_sh0[7:0], 8'h80);

        // Three frames with IN_VALID held high
        clear();
        frames[0] = 16'h9A12; frames[1] = 16'hBC34; frames[2] = 16'hDE56;
        nacc = 0;
        m_if.IN_DATA = frames[0]; m_if.IN_VALID = 1'b1;
        for (int i = 0; i < 150; i++) begin
            acc = m_if.IN_VALID && m_if.IN_READY;
            step();
            if (acc) begin
                nacc++;
                if (nacc == 2) check("s3_ready_drop", m_if.IN_READY, 1'b0);
                if (nacc < 3) m_if.IN_DATA = frames[nacc];
                else m_if.IN_VALID = 1'b0;
            end
        end
        check("s3_accepts",  nacc, 3);
        check("s3_entries",  fall_q.size(), 3);
        check("s3_period01", fall_q[1] - fall_q[0], 36);
        check("s3_period12", fall_q[2] - fall_q[1], 36);
        check("s3_busy_len", nbusy, 108);
        check("s3_fd_count", nfd, 3);
        check("s3_lane0",    sh0[23:0], 24'h123456);
        check("s3_lane1",    sh1[23:0], 24'h9ABCDE);

        // Handshake on the last LATCH cycle with hold empty
        clear();
        m_if.IN_DATA = 16'h11F0; m_if.IN_VALID = 1'b1;
        step();
        m_if.IN_VALID = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            step();
            if (m_fd === 1'b1) found = 1'b1;
        end
        check("s4_fd_seen", found, 1'b1);
        m_if.IN_DATA = 16'hA20F; m_if.IN_VALID = 1'b1;
        step();
        m_if.IN_VALID = 1'b0;
        check("s4_busy",  m_busy,  1'b1);
        check("s4_latch", m_latch, 1'b0);
        check("s4_bits",  m_sdata, 2'b10);
        check("s4_ready", m_if.IN_READY, 1'b1);
        repeat (50) step();
        check("s4_period",   fall_q[1] - fall_q[0], 36);
        check("s4_busy_len", nbusy, 72);
        check("s4_fd_count", nfd, 2);
        check("s4_lane0",    sh0[15:0], 16'hF00F);
        check("s4_lane1",    sh1[15:0], 16'h11A2);

        // Reset during bit 3 with a held frame
        clear();
        m_if.IN_DATA = 16'h1111; m_if.IN_VALID = 1'b1;
        step();
        m_if.IN_DATA = 16'h7777;
        step();
        m_if.IN_VALID = 1'b0;
        check("s5_held", m_if.IN_READY, 1'b0);
        repeat (12) step();
        RST_N = 1'b0;
        step();
        RST_N = 1'b1;
        check("s5_rst_latch", m_latch, 1'b1);
        check("s5_rst_sclk",  m_sclk,  1'b0);
        check("s5_rst_sdata", m_sdata, 2'b00);
        check("s5_rst_busy",  m_busy,  1'b0);
        check("s5_rst_ready", m_if.IN_READY, 1'b1);
        check("s5_rst_fd",    m_fd,    1'b0);
        clear();
        repeat (20) step();
        check("s5_quiet_lrise", nlrise, 0);
        check("s5_quiet_rise",  nrise,  0);
        check("s5_quiet_busy",  nbusy,  0);
        m_if.IN_DATA = 16'hC35A; m_if.IN_VALID = 1'b1;
        step();
        m_if.IN_VALID = 1'b0;
        repeat (50) step();
        check("s5_nrise",  nrise, 8);
        check("s5_lane0",  sh0[7:0], 8'h5A);
        check("s5_lane1",  sh1[7:0], 8'hC3);
        check("s5_lrise",  nlrise, 1);
        check("s5_fd",     nfd, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
